// File: rtl/prbs_checker.sv
// PRBS16 (x^16+x^14+x^13+x^11+1) serial checker: fills, searches for lock, then
// free-runs its own predictor and counts mismatches and compared bits.
module prbs_checker #(
    parameter int LOCK_THRESH   = 32,
    parameter int UNLOCK_THRESH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sh_en,
    input  logic        din,
    input  logic        clr_cnt,
    output logic        locked,
    output logic        err_tick,
    output logic [15:0] err_count,
    output logic [31:0] bit_count
);

    typedef enum logic [1:0] {FILL, SEARCH, LOCKED} state_t;

    localparam logic [7:0] LOCK_LAST   = 8'(LOCK_THRESH - 1);
    localparam logic [7:0] UNLOCK_LAST = 8'(UNLOCK_THRESH - 1);

    state_t      state_q, state_d;
    logic [15:0] shreg_q, shreg_d;
    logic [3:0]  fill_q, fill_d;
    logic [7:0]  match_q, match_d;
    logic [7:0]  miss_q, miss_d;
    logic        locked_q, locked_d;
    logic        tick_q, tick_d;
    logic [15:0] errc_q, errc_d;
    logic [31:0] bitc_q, bitc_d;
    logic        pred;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign pred = shreg_q[15] ^ shreg_q[13] ^ shreg_q[12] ^ shreg_q[10];

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        fill_d   = fill_q;
        match_d  = match_q;
        miss_d   = miss_q;
        locked_d = locked_q;
        tick_d   = 1'b0;
        errc_d   = errc_q;
        bitc_d   = bitc_q;
        if (sh_en) begin
            case (state_q)
                FILL: begin
                    shreg_d = {shreg_q[14:0], din};
                    fill_d  = fill_q + 4'd1;
                    if (fill_q == 4'd15) begin
                        state_d = SEARCH;
                        match_d = 8'd0;
                    end
                end
                SEARCH: begin
                    shreg_d = {shreg_q[14:0], din};
                    // An all-zero history predicts zero forever, so it never counts as a match.
                    if (din == pred && shreg_q != 16'h0000) begin
                        if (match_q == LOCK_LAST) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                            match_d  = 8'd0;
                            miss_d   = 8'd0;
                        end else begin
                            match_d = match_q + 8'd1;
                        end
                    end else begin
                        match_d = 8'd0;
                    end
                end
                LOCKED: begin
                    shreg_d = {shreg_q[14:0], pred};
                    bitc_d  = sat_inc32(bitc_q);
                    if (din != pred) begin
                        tick_d = 1'b1;
                        errc_d = sat_inc16(errc_q);
                        if (miss_q == UNLOCK_LAST) begin
                            state_d  = FILL;
                            locked_d = 1'b0;
                            fill_d   = 4'd0;
                            match_d  = 8'd0;
                            miss_d   = 8'd0;
                        end else begin
                            miss_d = miss_q + 8'd1;
                        end
                    end else begin
                        miss_d = 8'd0;
                    end
                end
                default: state_d = FILL;
            endcase
        end
        if (clr_cnt) begin
            errc_d = 16'd0;
            bitc_d = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FILL;
            shreg_q  <= 16'h0000;
            fill_q   <= 4'd0;
            match_q  <= 8'd0;
            miss_q   <= 8'd0;
            locked_q <= 1'b0;
            tick_q   <= 1'b0;
            errc_q   <= 16'd0;
            bitc_q   <= 32'd0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            fill_q   <= fill_d;
            match_q  <= match_d;
            miss_q   <= miss_d;
            locked_q <= locked_d;
            tick_q   <= tick_d;
            errc_q   <= errc_d;
            bitc_q   <= bitc_d;
        end
    end

    assign locked    = locked_q;
    assign err_tick  = tick_q;
    assign err_count = errc_q;
    assign bit_count = bitc_q;

endmodule
